rv_avmm_rr_arbiter: RTL and testbench
=====================================

// Module: rv_avmm_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Avalon-MM slave port (the rv_avmm2axi bridge) between N_REQ Avalon-MM requesters.
//  Grants one requester at a time, forwards its command, and returns the bridge's waitrequest/readdata to it only.
//  Holds the grant until the transfer completes. Sits between CPU/DMA-side masters and the AXI-Lite bridge.
// PARAMETERS
//  N_REQ            2    number of requesters (2..8)
//  ADDR_WIDTH       14   address width
//  DATA_WIDTH       32   data width
//  BYTEENABLE_WIDTH DATA_WIDTH/8  byte enable width
//  TIMEOUT_CYCLES   1024 busy cycles before timeout_err sets (>=2)
// PORTS
//  clk            in   1                  clock; all logic on rising edge
//  rst            in   1                  synchronous reset, active-high
//  r_address      in   N_REQ*ADDR_WIDTH   requester addresses, req i at [i*AW +: AW]
//  r_byteenable   in   N_REQ*BE_WIDTH     requester byte enables
//  r_read         in   N_REQ              requester read strobes
//  r_write        in   N_REQ              requester write strobes
//  r_writedata    in   N_REQ*DATA_WIDTH   requester write data
//  r_readdata     out  N_REQ*DATA_WIDTH   s_readdata fanned to every requester
//  r_waitrequest  out  N_REQ              per-requester waitrequest
//  s_address      out  ADDR_WIDTH         to bridge d_address
//  s_byteenable   out  BE_WIDTH           to bridge d_byteenable
//  s_read         out  1                  to bridge d_read
//  s_write        out  1                  to bridge d_write
//  s_writedata    out  DATA_WIDTH         to bridge d_writedata
//  s_readdata     in   DATA_WIDTH         from bridge d_readdata
//  s_waitrequest  in   1                  from bridge d_waitrequest
//  grant          out  N_REQ              one-hot current grant, registered
//  timeout_err    out  1                  sticky, transfer exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: grant=0, state IDLE, rr pointer=0, busy counter=0, timeout_err=0.
//   Also s_read=s_write=0 and all r_waitrequest=1.
//  req[i] = r_read[i] | r_write[i].
//  FSM IDLE:
//   - All r_waitrequest=1, s_read=s_write=0.
//   - If any req: grant the first requesting index at or after the pointer, wrapping modulo N_REQ. Go to BUSY.
//   - A request seen at edge t gives grant and s_* valid in cycle t+1. Grant latency is 1 cycle.
//  FSM BUSY (granted g):
//   - s_* is a combinational mux of requester g.
//   - If r_write[g] & r_read[g] are both high, write wins and s_read=0.
//   - r_waitrequest[g]=s_waitrequest; all others = 1.
//   - Completion = (s_read|s_write) & ~s_waitrequest. Requester g sees waitrequest low in that cycle.
//     For a read, r_readdata is valid in that same cycle.
//   - On the completion edge: state->IDLE, grant=0, pointer=(g+1) mod N_REQ.
//     The next transfer therefore starts at earliest 1 cycle later, after one IDLE bubble.
//     The bubble lets the bridge FSMs return to idle.
//   - Abort: if req[g]==0 while BUSY (illegal Avalon), go to IDLE. Pointer is unchanged. No error.
//  Busy counter:
//   - Cleared on entering BUSY, increments each BUSY cycle, saturates.
//   - If it reaches TIMEOUT_CYCLES, set timeout_err. The grant is NOT released.
//   - timeout_err is cleared only by rst.
//  Simultaneous requests:
//   - The pointer gives strict round-robin.
//   - A requester continuously requesting waits at most N_REQ-1 transfers.
//  Reset mid-transfer: next edge gives IDLE, grant=0, s_read=s_write=0.
//   The bridge must be reset together with this block.
//  Non-granted requesters must hold their command stable while waitrequest=1 (Avalon rule).
// TESTING
//  1 Single write: r_write[0]=1, addr 0x0010, data 0xDEADBEEF, s_waitrequest low 4 cycles later.
//    -> grant=01 at t+1; s_write with same addr/data; r_waitrequest[0] low exactly 1 cycle; then IDLE.
//  2 Single read: r_read[1]=1, addr 0x0200, s_readdata=0x12345678 with s_waitrequest low.
//    -> r_waitrequest[1] low in that cycle, r_readdata=0x12345678; pointer=0 afterward.
//  3 Contention: both requesters request continuously, 4 transfers.
//    -> grant order 0,1,0,1; each completion followed by a 1-cycle IDLE with grant=0.
//  4 Timeout: TIMEOUT_CYCLES=8, s_waitrequest held high.
//    -> timeout_err=1 after 8 BUSY cycles; grant held; timeout_err stays 1 after the transfer completes.
//  5 Reset mid-transfer: rst during BUSY with grant=10.
//    -> next cycle grant=0, s_read=s_write=0, all r_waitrequest=1, pointer=0.
//  6 Abort and write priority: drop r_write[0] while BUSY -> IDLE with pointer unchanged.
//    r_read[0]=r_write[0]=1 -> s_write=1, s_read=0.

Source files
------------

// File: rtl/rv_avmm_rr_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM slave port (the AXI-Lite bridge)
// between N_REQ Avalon-MM requesters, holding each grant until its transfer completes.
module rv_avmm_rr_arbiter #(
    parameter int N_REQ            = 2,
    parameter int ADDR_WIDTH       = 14,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ*ADDR_WIDTH-1:0]       r_address,
    input  logic [N_REQ*BYTEENABLE_WIDTH-1:0] r_byteenable,
    input  logic [N_REQ-1:0]                  r_read,
    input  logic [N_REQ-1:0]                  r_write,
    input  logic [N_REQ*DATA_WIDTH-1:0]       r_writedata,
    output logic [N_REQ*DATA_WIDTH-1:0]       r_readdata,
    output logic [N_REQ-1:0]                  r_waitrequest,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic [BYTEENABLE_WIDTH-1:0]       s_byteenable,
    output logic                              s_read,
    output logic                              s_write,
    output logic [DATA_WIDTH-1:0]             s_writedata,
    input  logic [DATA_WIDTH-1:0]             s_readdata,
    input  logic                              s_waitrequest,
    output logic [N_REQ-1:0]                  grant,
    output logic                              timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] req;
    logic [CNT_W-1:0] busy_cnt;
    logic             complete;

    assign req        = r_read | r_write;
    assign complete   = (s_read | s_write) & ~s_waitrequest;
    assign r_readdata = {N_REQ{s_readdata}};

    // Walk offsets from the farthest back to the pointer so the nearest requester wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving BUSY covers both a normal completion and a requester that dropped its command.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_valid) state_next = BUSY;
            BUSY: if (!req[gidx] || complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write wins when a requester illegally raises both strobes.
    always_comb begin
        s_address     = r_address[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        s_byteenable  = r_byteenable[int'(gidx)*BYTEENABLE_WIDTH +: BYTEENABLE_WIDTH];
        s_writedata   = r_writedata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        s_read        = 1'b0;
        s_write       = 1'b0;
        r_waitrequest = '1;
        if (state == BUSY) begin
            s_write             = r_write[gidx];
            s_read              = r_read[gidx] & ~r_write[gidx];
            r_waitrequest[gidx] = s_waitrequest;
        end
    end

    // The pointer only advances on a real completion; an abort leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            gidx        <= '0;
            ptr         <= '0;
            busy_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gidx     <= pick_idx;
                        grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (busy_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                    if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                    end
                    if (state_next == IDLE) begin
                        grant <= '0;
                    end
                    if (complete) begin
                        ptr <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_avmm_rr_arbiter.sv
// Directed bench for the two-requester round-robin Avalon-MM arbiter,
// with a short timeout so the sticky error path is reachable.
module tb_rv_avmm_rr_arbiter;

    localparam int N   = 2;
    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int BEW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   r_address;
    logic [N*BEW-1:0]  r_byteenable;
    logic [N-1:0]      r_read;
    logic [N-1:0]      r_write;
    logic [N*DW-1:0]   r_writedata;
    logic [N*DW-1:0]   r_readdata;
    logic [N-1:0]      r_waitrequest;
    logic [AW-1:0]     s_address;
    logic [BEW-1:0]    s_byteenable;
    logic              s_read;
    logic              s_write;
    logic [DW-1:0]     s_writedata;
    logic [DW-1:0]     s_readdata;
    logic              s_waitrequest;
    logic [N-1:0]      grant;
    logic              timeout_err;

    int checks = 0;
    int passed = 0;

    rv_avmm_rr_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BYTEENABLE_WIDTH(BEW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .r_address(r_address), .r_byteenable(r_byteenable),
        .r_read(r_read), .r_write(r_write), .r_writedata(r_writedata),
        .r_readdata(r_readdata), .r_waitrequest(r_waitrequest),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr, input logic sw);
        r_read        = rd;
        r_write       = wr;
        s_waitrequest = sw;
        #1;
    endtask

    logic [1:0] rrOrder [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rst = 1'b1;
        r_address = '0; r_byteenable = '0; r_writedata = '0;
        r_read = '0; r_write = '0; s_readdata = '0; s_waitrequest = 1'b1;
        nextCycle(); nextCycle();
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_sread", s_read, 0);
        checkOutput("rst_swrite", s_write, 0);
        checkOutput("rst_rwait", r_waitrequest, 2'b11);
        checkOutput("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Single write from requester 0
        r_address[AW-1:0]   = 14'h0010;
        r_writedata[DW-1:0] = 32'hDEADBEEF;
        r_byteenable[3:0]   = 4'hF;
        applyStimulus(2'b00, 2'b01, 1'b1);
        checkOutput("w_idle_grant", grant, 0);
        checkOutput("w_idle_rwait", r_waitrequest, 2'b11);
        nextCycle();
        checkOutput("w_grant", grant, 2'b01);
        checkOutput("w_swrite", s_write, 1);
        checkOutput("w_sread", s_read, 0);
        checkOutput("w_addr", s_address, 14'h0010);
        checkOutput("w_data", s_writedata, 32'hDEADBEEF);
        checkOutput("w_be", s_byteenable, 4'hF);
        checkOutput("w_rwait_hold", r_waitrequest, 2'b11);
        repeat (3) nextCycle();
        checkOutput("w_grant_held", grant, 2'b01);
        applyStimulus(2'b00, 2'b01, 1'b0);
        checkOutput("w_rwait_done", r_waitrequest, 2'b10);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("w_after_grant", grant, 0);
        checkOutput("w_after_rwait", r_waitrequest, 2'b11);
        checkOutput("w_after_swrite", s_write, 0);

        // Single read from requester 1
        r_address[2*AW-1:AW] = 14'h0200;
        applyStimulus(2'b10, 2'b00, 1'b1);
        nextCycle();
        checkOutput("r_grant", grant, 2'b10);
        checkOutput("r_sread", s_read, 1);
        checkOutput("r_addr", s_address, 14'h0200);
        s_readdata = 32'h12345678;
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("r_rwait", r_waitrequest, 2'b01);
        checkOutput("r_rdata1", r_readdata[2*DW-1:DW], 32'h12345678);
        checkOutput("r_rdata0", r_readdata[DW-1:0], 32'h12345678);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("r_after_grant", grant, 0);

        // Contention: both write continuously, zero-wait slave
        r_address[AW-1:0]    = 14'h0030;
        r_address[2*AW-1:AW] = 14'h0040;
        applyStimulus(2'b00, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("rr_grant%0d", i), grant, rrOrder[i]);
            checkOutput($sformatf("rr_addr%0d", i), s_address, (rrOrder[i] == 2'b01) ? 14'h0030 : 14'h0040);
            nextCycle();
            checkOutput($sformatf("rr_bubble%0d", i), grant, 0);
            checkOutput($sformatf("rr_bubble_wr%0d", i), s_write, 0);
        end
        applyStimulus(2'b00, 2'b00, 1'b1);

        // Abort leaves the pointer at 0, then write beats read
        applyStimulus(2'b00, 2'b01, 1'b1);
        nextCycle();
        checkOutput("ab_grant", grant, 2'b01);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("ab_swrite", s_write, 0);
        nextCycle();
        checkOutput("ab_idle", grant, 0);
        applyStimulus(2'b01, 2'b11, 1'b1);
        nextCycle();
        checkOutput("ab_ptr_kept", grant, 2'b01);
        checkOutput("prio_swrite", s_write, 1);
        checkOutput("prio_sread", s_read, 0);
        applyStimulus(2'b01, 2'b11, 1'b0);
        checkOutput("prio_rwait", r_waitrequest, 2'b10);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("prio_after", grant, 0);
        checkOutput("prio_timeout", timeout_err, 0);

        // Timeout: slave stalls, requester 0 wraps around from pointer 1
        applyStimulus(2'b01, 2'b00, 1'b1);
        nextCycle();
        checkOutput("to_grant", grant, 2'b01);
        repeat (7) nextCycle();
        checkOutput("to_cycle8", timeout_err, 0);
        nextCycle();
        checkOutput("to_cycle9", timeout_err, 1);
        checkOutput("to_grant_held", grant, 2'b01);
        repeat (3) nextCycle();
        s_readdata = 32'hCAFEF00D;
        applyStimulus(2'b01, 2'b00, 1'b0);
        checkOutput("to_rwait", r_waitrequest, 2'b10);
        checkOutput("to_rdata", r_readdata[DW-1:0], 32'hCAFEF00D);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("to_after_grant", grant, 0);
        checkOutput("to_sticky", timeout_err, 1);

        // Reset in the middle of a requester-1 transfer
        applyStimulus(2'b10, 2'b00, 1'b1);
        nextCycle();
        checkOutput("mr_grant", grant, 2'b10);
        rst = 1'b1;
        nextCycle();
        checkOutput("mr_grant0", grant, 0);
        checkOutput("mr_sread", s_read, 0);
        checkOutput("mr_swrite", s_write, 0);
        checkOutput("mr_rwait", r_waitrequest, 2'b11);
        checkOutput("mr_timeout", timeout_err, 0);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 1'b1);
        nextCycle();
        checkOutput("mr_ptr0", grant, 2'b01);
        applyStimulus(2'b00, 2'b00, 1'b1);
        nextCycle();
        checkOutput("mr_end", grant, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
